// File: rtl/vedic_mac_accum.sv
// Multiply-accumulate back end: sums up to FRAME_LEN unsigned products per frame and
// hands each sum out over valid/ready. Define VEDIC_ACC_SAT_EN to saturate instead of wrap.
module vedic_mac_accum #(
  parameter int PROD_W    = 32,
  parameter int ACC_W     = 40,
  parameter int FRAME_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic [7:0]        acc_count,
  output logic              acc_ovf
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0] FRAME_END = 8'(FRAME_LEN);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] sum, sum_nxt;
  logic [7:0]       count, count_inc;
  logic             ovf, ovf_nxt;
  logic [ACC_W:0]   add;
  logic             beat, close, handoff;

  assign beat      = prod_valid && prod_ready;
  assign add       = {1'b0, sum} + (ACC_W+1)'(prod_data);
  assign count_inc = count + 8'd1;
  assign ovf_nxt   = ovf | add[ACC_W];
  assign close     = (count_inc == FRAME_END) || prod_last;
  assign handoff   = (state == HOLD) && acc_ready;

`ifdef VEDIC_ACC_SAT_EN
  // Once clamped, any later nonzero add carries again, so the sum stays pinned.
  assign sum_nxt = ovf_nxt ? {ACC_W{1'b1}} : add[ACC_W-1:0];
`else
  assign sum_nxt = add[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    case (state)
      ACCUM: begin
        prod_ready = 1'b1;
        if (beat && close) state_nxt = HOLD;
      end
      HOLD: begin
        acc_valid = 1'b1;
        if (acc_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      acc_data  <= '0;
      acc_count <= '0;
      acc_ovf   <= 1'b0;
    end else if (beat) begin
      sum   <= sum_nxt;
      count <= count_inc;
      ovf   <= ovf_nxt;
      if (close) begin
        acc_data  <= sum_nxt;
        acc_count <= count_inc;
        acc_ovf   <= ovf_nxt;
      end
    end else if (handoff) begin
      // Result registers keep the last sum; only the running frame state restarts.
      sum   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end
  end

endmodule
